eaglesong_squeeze_seq: RTL and testbench

EAGLESONG_SQUEEZE_SEQ -- requirements
Module: eaglesong_squeeze_seq

---
 rtl/eaglesong_squeeze_seq.sv | 169 ++++++++++++++++
 tb/tb_eaglesong_squeeze_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_squeeze_seq.sv
// eaglesong_squeeze_seq -- sequential byte-serial squeeze stage of the
// Eaglesong sponge.
//
// Takes the post-permutation sponge state and streams digest bytes out over a
// valid/ready handshake. Each squeeze block is the 32-byte rate: 8 words,
// word 0 first, big-endian within a word. When the digest needs more than one
// rate block, the block asks an external permutation for a fresh state
// (perm_req/perm_done) and then carries on.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   start                   pulse, request a squeeze of state_input
//   state_input[31:0][7:0]  sponge state, 256 bits; word w = bits [32w+31:32w]
//   output_length_bytes     requested digest length, 1..MAX_OUT_BYTES
//   perm_req                high while waiting on the external permutation
//   perm_done, perm_state   permutation result (perm_done is a pulse)
//   out_byte, out_valid,
//   out_ready, out_last     digest byte stream
//   busy                    high whenever the FSM is not IDLE
//   len_err                 one-cycle pulse when a start is rejected
//   digest_out[255:0]       only with EAGLESONG_SQUEEZE_DIGEST_REG_EN:
//                           the first 32 digest bytes, byte i at [8i +: 8]
//
// Build option: define EAGLESONG_SQUEEZE_DIGEST_REG_EN to add digest_out.
module eaglesong_squeeze_seq #(
  parameter int MAX_OUT_BYTES = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [31:0][7:0] state_input,
  input  logic [6:0]      output_length_bytes,
  output logic            perm_req,
  input  logic            perm_done,
  input  logic [31:0][7:0] perm_state,
  output logic [7:0]      out_byte,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            len_err
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
  ,
  output logic [255:0]    digest_out
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, PERM_WAIT} state_t;

  state_t       state_q, state_d;
  logic [255:0] held_q;
  logic [6:0]   idx_q, len_q;
  logic [7:0]   out_byte_q;
  logic         out_last_q, len_err_q;

  logic         len_ok, accept, reject, xfer, load_perm;
  logic [6:0]   idx_inc, len_m1;

  // Rate byte r: word r/4, bits [31-8*(r%4) -: 8] (big-endian in the word).
  function automatic logic [7:0] rate_byte(input logic [255:0] s, input logic [4:0] r);
    logic [31:0] w;
    w = s[{r[4:2], 5'b00000} +: 32];
    return w[{~r[1:0], 3'b000} +: 8];
  endfunction

  assign len_ok  = (output_length_bytes != 7'd0) &&
                   (32'(output_length_bytes) <= 32'(MAX_OUT_BYTES));
  assign idx_inc = idx_q + 7'd1;
  assign len_m1  = len_q - 7'd1;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    xfer      = 1'b0;
    load_perm = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept  = 1'b1;
            state_d = EMIT;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          xfer = 1'b1;
          if (out_last_q)               state_d = IDLE;
          // Rate exhausted with bytes still owed: fetch a new state.
          else if (idx_q[4:0] == 5'd31) state_d = PERM_WAIT;
        end
      end
      PERM_WAIT: begin
        if (perm_done) begin
          load_perm = 1'b1;
          state_d   = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // out_byte/out_last are precomputed into registers so they are stable
  // across stalls and the next byte is ready the cycle after a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      out_byte_q <= 8'h00;
      out_last_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= reject;
      if (accept) begin
        held_q     <= state_input;
        len_q      <= output_length_bytes;
        idx_q      <= '0;
        out_byte_q <= rate_byte(state_input, 5'd0);
        out_last_q <= (output_length_bytes == 7'd1);
      end else if (xfer) begin
        idx_q <= idx_inc;
        if (state_d == EMIT) begin
          out_byte_q <= rate_byte(held_q, idx_inc[4:0]);
          out_last_q <= (idx_inc == len_m1);
        end else begin
          out_last_q <= 1'b0;
        end
      end else if (load_perm) begin
        // idx already points at rate byte 0 of the new block.
        held_q     <= perm_state;
        out_byte_q <= rate_byte(perm_state, idx_q[4:0]);
        out_last_q <= (idx_q == len_m1);
      end
    end
  end

`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
  logic [255:0] digest_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digest_q <= '0;
    end else if (accept) begin
      digest_q <= '0;
    end else if (xfer && (idx_q[6:5] == 2'b00)) begin
      digest_q[{idx_q[4:0], 3'b000} +: 8] <= out_byte_q;
    end
  end

  assign digest_out = digest_q;
`endif

  assign out_valid = (state_q == EMIT);
  assign perm_req  = (state_q == PERM_WAIT);
  assign busy      = (state_q != IDLE);
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_eaglesong_squeeze_seq.sv
// Directed self-checking bench for eaglesong_squeeze_seq. Inputs are driven
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_eaglesong_squeeze_seq;

  logic             clk, reset_n, start, perm_req, perm_done;
  logic [31:0][7:0] state_input, perm_state;
  logic [6:0]       output_length_bytes;
  logic [7:0]       out_byte;
  logic             out_valid, out_ready, out_last, busy, len_err;
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
  logic [255:0]     digest_out;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Rate words 0..7, word 0 in the low 32 bits.
  localparam logic [255:0] ST = {32'hEA6F07F0, 32'h0F1E2D3C, 32'hDDEEFF00, 32'h99AABBCC,
                                 32'h55667788, 32'h11223344, 32'hF3FD8315, 32'h21AB5F07};

  eaglesong_squeeze_seq #(.MAX_OUT_BYTES(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .state_input(state_input),
    .output_length_bytes(output_length_bytes), .perm_req(perm_req),
    .perm_done(perm_done), .perm_state(perm_state), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .len_err(len_err)
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
    , .digest_out(digest_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mdl(input logic [255:0] s, input int r);
    logic [31:0] w;
    w = s[32*(r/4) +: 32];
    return w[31-8*(r%4) -: 8];
  endfunction

  task automatic do_start(input logic [6:0] len);
    start = 1'b1;
    output_length_bytes = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; perm_done = 1'b0; out_ready = 1'b1;
    state_input = ST; perm_state = '0; output_length_bytes = 7'd0;
    repeat (2) @(posedge clk); #1;
    tot_cnt++;
    if ({out_valid, out_last, perm_req, busy, len_err, out_byte} !== 13'h0)
      $display("FAIL reset_outputs: got %h want 0", {out_valid, out_last, perm_req, busy, len_err, out_byte});
    else pass_cnt++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] exp4 [4];
    exp4 = '{8'h21, 8'hAB, 8'h5F, 8'h07};
    state_input = ST; out_ready = 1'b1;
    do_start(7'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tot_cnt++;
      if ({out_valid, out_last, out_byte} !== {1'b1, (i == 3), exp4[i]})
        $display("FAIL basic_byte%0d: got v/l/b %b/%b/%h want 1/%b/%h", i, out_valid, out_last, out_byte, (i == 3), exp4[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    tot_cnt++;
    if ({busy, out_valid} !== 2'b00) $display("FAIL basic_idle: got busy/valid %b/%b want 0/0", busy, out_valid);
    else pass_cnt++;
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
    tot_cnt++;
    if (digest_out !== 256'h075FAB21) $display("FAIL basic_digest: got %h want 075fab21", digest_out);
    else pass_cnt++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_perm();
    // perm_done while idle must do nothing.
    perm_state = '1; perm_done = 1'b1;
    @(posedge clk); #1;
    perm_done = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if ({busy, perm_req, out_valid} !== 3'b000) $display("FAIL perm_idle_ignore: got %b want 000", {busy, perm_req, out_valid});
    else pass_cnt++;
    @(posedge clk); #1;

    state_input = ST; out_ready = 1'b1;
    do_start(7'd34);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      tot_cnt++;
      if ({out_valid, out_last, out_byte} !== {1'b1, 1'b0, mdl(ST, i)})
        $display("FAIL perm_blk0_byte%0d: got v/l/b %b/%b/%h want 1/0/%h", i, out_valid, out_last, out_byte, mdl(ST, i));
      else pass_cnt++;
      if (i == 31) begin
        tot_cnt++;
        if (out_byte !== 8'hF0) $display("FAIL perm_byte31: got %h want f0", out_byte); else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tot_cnt++;
      if ({perm_req, out_valid, busy} !== 3'b101)
        $display("FAIL perm_wait%0d: got req/valid/busy %b/%b/%b want 1/0/1", k, perm_req, out_valid, busy);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    perm_state = {224'h0, 32'h00112233};
    perm_done = 1'b1;
    @(posedge clk); #1;
    perm_done = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if ({out_valid, out_last, perm_req, out_byte} !== {3'b100, 8'h00})
      $display("FAIL perm_byte32: got v/l/req/b %b/%b/%b/%h want 1/0/0/00", out_valid, out_last, perm_req, out_byte);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    tot_cnt++;
    if ({out_valid, out_last, out_byte} !== {2'b11, 8'h11})
      $display("FAIL perm_byte33: got v/l/b %b/%b/%h want 1/1/11", out_valid, out_last, out_byte);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    tot_cnt++;
    if ({busy, out_valid} !== 2'b00) $display("FAIL perm_done_idle: got busy/valid %b/%b want 0/0", busy, out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic pat [4];
    int n, cyc;
    logic [7:0] prev;
    logic prev_stall, saw_perm, done;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n = 0; cyc = 0; prev = 8'h00; prev_stall = 1'b0; saw_perm = 1'b0; done = 1'b0;
    state_input = ST;
    do_start(7'd32);
    while (!done && cyc < 200) begin
      out_ready = pat[cyc % 4];
      @(negedge clk);
      if (perm_req) saw_perm = 1'b1;
      if (out_valid && prev_stall) begin
        tot_cnt++;
        if (out_byte !== prev) $display("FAIL stall_hold_cyc%0d: got %h want %h", cyc, out_byte, prev);
        else pass_cnt++;
      end
      if (out_valid && out_ready) begin
        tot_cnt++;
        if ({out_last, out_byte} !== {(n == 31), mdl(ST, n)})
          $display("FAIL stall_xfer%0d: got l/b %b/%h want %b/%h", n, out_last, out_byte, (n == 31), mdl(ST, n));
        else pass_cnt++;
        if (out_last) done = 1'b1;
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev = out_byte;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    tot_cnt++;
    if (n !== 32) $display("FAIL stall_count: got %0d transfers want 32", n); else pass_cnt++;
    tot_cnt++;
    if (saw_perm !== 1'b0) $display("FAIL stall_no_perm: got perm_req %b want 0", saw_perm); else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL stall_idle: got busy %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_len_err();
    logic [6:0] bad [2];
    logic [7:0] exp4 [4];
    bad = '{7'd0, 7'd65};
    exp4 = '{8'h21, 8'hAB, 8'h5F, 8'h07};
    for (int j = 0; j < 2; j++) begin
      do_start(bad[j]);
      @(negedge clk);
      tot_cnt++;
      if ({len_err, busy} !== 2'b10) $display("FAIL len_err_pulse_len%0d: got err/busy %b/%b want 1/0", bad[j], len_err, busy);
      else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      tot_cnt++;
      if ({len_err, busy} !== 2'b00) $display("FAIL len_err_clear_len%0d: got err/busy %b/%b want 0/0", bad[j], len_err, busy);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    state_input = ST; out_ready = 1'b1;
    do_start(7'd4);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin start = 1'b1; output_length_bytes = 7'd1; state_input = '0; end
      if (i == 2) begin start = 1'b0; state_input = ST; end
      @(negedge clk);
      tot_cnt++;
      if ({out_valid, out_last, len_err, out_byte} !== {1'b1, (i == 3), 1'b0, exp4[i]})
        $display("FAIL busy_start_byte%0d: got v/l/err/b %b/%b/%b/%h want 1/%b/0/%h", i, out_valid, out_last, len_err, out_byte, (i == 3), exp4[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    tot_cnt++;
    if ({busy, len_err} !== 2'b00) $display("FAIL busy_start_end: got busy/err %b/%b want 0/0", busy, len_err);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    state_input = ST; out_ready = 1'b1;
    do_start(7'd34);
    repeat (10) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    tot_cnt++;
    if ({out_valid, out_last, perm_req, busy, len_err, out_byte} !== 13'h0)
      $display("FAIL midreset_outputs: got %h want 0", {out_valid, out_last, perm_req, busy, len_err, out_byte});
    else pass_cnt++;
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
    tot_cnt++;
    if (digest_out !== 256'h0) $display("FAIL midreset_digest: got %h want 0", digest_out); else pass_cnt++;
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_start(7'd1);
    @(negedge clk);
    tot_cnt++;
    if ({out_valid, out_last, out_byte} !== {2'b11, 8'h21})
      $display("FAIL midreset_restart: got v/l/b %b/%b/%h want 1/1/21", out_valid, out_last, out_byte);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    tot_cnt++;
    if ({busy, out_valid} !== 2'b00) $display("FAIL midreset_end: got busy/valid %b/%b want 0/0", busy, out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_perm();
    test_stall();
    test_len_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
